jk_cmd_sequencer: RTL and testbench
===================================

Name: jk_cmd_sequencer

Overview:
Upstream driver stage for the team's JK flip-flop cell. Accepts queued commands (hold/reset/set/toggle plus repeat count) over a valid/ready handshake, buffers them in a small FIFO, and drives registered j/k for the commanded number of cycles. Maintains q_exp, a cycle-accurate model of the downstream flop's q, for in-system checking.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, at least 2.
CW, 4, repeat-count width in bits.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
en  input  1  1 = run; 0 = pause (outputs hold code, countdown frozen)
in_valid  input  1  command offered
in_ready  output  1  FIFO can accept
in_op  input  2  {j,k} code: 00 hold, 01 reset, 10 set, 11 toggle
in_cnt  input  CW  repeat count; op is driven for in_cnt+1 cycles
j  output  1  registered J to the downstream flop
k  output  1  registered K to the downstream flop
q_exp  output  1  predicted downstream q
busy  output  1  command in execution or FIFO non-empty
level  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, level=0, state IDLE, j=0, k=0, q_exp=0, busy=0, in_ready=1. Reset mid-command discards the active command and all queued commands. Deassertion is synchronous to clk in the surrounding design.
- Push: at a clk edge with in_valid=1 and in_ready=1, {in_op, in_cnt} is written. in_ready = (level != DEPTH), derived from registered occupancy only. There is no ready-through on a same-cycle pop: when full, in_ready=0 even if a pop occurs that cycle.
- Pop: only from registered occupancy before the edge. There is no bypass, so an entry pushed at edge T can first pop at edge T+1. Simultaneous push and pop leave level unchanged.
- State machine (IDLE, RUN), evaluated only when en=1:
  - IDLE: if level>0, pop and load {j,k}<=op and rem<=cnt, then go to RUN. Otherwise {j,k}<=00.
  - RUN with rem>0: rem<=rem-1, and {j,k} holds the op.
  - RUN with rem=0 and level>0: pop the next entry back-to-back with no idle cycle, load it, stay in RUN.
  - RUN with rem=0 and level=0: {j,k}<=00, go to IDLE.
- Cycle counts: a command with cnt=N drives its op for exactly N+1 consecutive enabled cycles. Minimum latency from accepting edge T to j/k showing the op is one edge (visible after T+1).
- en=0: at the next edge {j,k}<=00. State, rem and FIFO read pointer are frozen, but pushes are still accepted. When en returns to 1, the op is re-driven and the remaining count resumes. Paused cycles do not count toward N+1.
- q_exp: updated at every edge from the current registered j, k and q_exp, using 00 -> q, 01 -> 0, 10 -> 1, 11 -> ~q. It therefore matches the flop's q after the same edge.
- busy = (state==RUN) or (level>0).
- Pointers are log2(DEPTH) bits wide and wrap naturally. level saturates by construction: no push when full, no pop when empty.
- in_cnt width rules: the counter is CW bits, and cnt = 2^CW-1 gives 2^CW cycles with no overflow.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, with in_valid=0 for 10 cycles -> j=k=0, q_exp=0, busy=0, level=0, in_ready=1 throughout.
- Single set: push op=10, cnt=2 at edge T -> j=1, k=0 for exactly edges T+1..T+3, then 00. q_exp=1 from T+2 onward. busy drops after T+4.
- Back-to-back toggle: push op=11 cnt=3, then op=01 cnt=0 -> four toggle cycles with q_exp sequence 1,0,1,0, immediately followed by one 01 cycle with no 00 gap. q_exp=0, then idle.
- Full/backpressure: with en=0, push 5 commands at DEPTH=4 -> in_ready=0 after the 4th accept, level=4, and the 5th is held off. Raising en drains all four in order, and in_ready returns the cycle after the first pop.
- Pause mid-command: op=10 cnt=5, with en=0 for 3 cycles after 2 driven cycles -> j/k=00 during the pause, then exactly 4 more set cycles (6 total).
- Async reset mid-run: assert rst=0 between edges during a toggle burst with 3 queued -> j, k, q_exp, level and busy go to 0 immediately without a clk edge, and no queued command executes after release.

Source files
------------

// File: rtl/jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// jk_cmd_sequencer
//
// Upstream driver for the JK flip-flop cell. Commands ({j,k} op plus a repeat
// count) arrive over a valid/ready handshake and are buffered in a small
// FIFO. Each command drives its op on registered j/k for cnt+1 enabled
// cycles, back-to-back with the next queued command. q_exp tracks what the
// downstream flop's q will be after each edge, for in-system checking.
//
// Parameters:
//   DEPTH  command FIFO entries (power of 2, >= 2)
//   CW     repeat-count width in bits
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-low reset
//   en        1 = run, 0 = pause (j/k forced to 00, countdown frozen)
//   in_valid  command offered
//   in_ready  FIFO can accept (from registered occupancy only)
//   in_op     {j,k} code: 00 hold, 01 reset, 10 set, 11 toggle
//   in_cnt    repeat count; op is driven for in_cnt+1 cycles
//   j, k      registered J/K to the downstream flop
//   q_exp     predicted downstream q
//   busy      command in execution or FIFO non-empty
//   level     FIFO occupancy
// ---------------------------------------------------------------------------
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [CW-1:0]          in_cnt,
  output logic                   j,
  output logic                   k,
  output logic                   q_exp,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LEVEL_W = AW + 1;
  localparam logic [AW:0] LEVEL_FULL = LEVEL_W'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [CW+1:0] fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [0:0]    state;
  logic [CW-1:0] rem;
  logic [1:0]    cur_op;
  logic [1:0]    head_op;
  logic [CW-1:0] head_cnt;
  logic          fifo_nonempty;
  logic          push;
  logic          pop;

  // Handshake and FIFO control. in_ready looks only at registered occupancy,
  // so a full FIFO stays closed even on a cycle where an entry is popped.
  // A pop happens whenever the sequencer is enabled and about to load a new
  // command: either sitting idle, or finishing the last cycle of the active
  // one. Because the pop decision also uses registered occupancy, an entry
  // pushed at one edge can first be popped at the following edge.
  assign fifo_nonempty = (level != '0);
  assign in_ready      = (level != LEVEL_FULL);
  assign push          = in_valid && in_ready;
  assign pop           = en && fifo_nonempty && ((state == ST_IDLE) || (rem == '0));
  assign {head_op, head_cnt} = fifo_mem[rd_ptr];
  assign busy          = (state == ST_RUN) || fifo_nonempty;

  // Command storage. The payload memory needs no reset: an entry is only
  // ever read once occupancy says it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {in_op, in_cnt};
    end
  end

  // FIFO pointers and occupancy. Pointers are exactly log2(DEPTH) bits and
  // wrap on their own; occupancy cannot over- or underflow since push is
  // gated by in_ready and pop by a non-empty FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sequencer. rem counts the cycles still to be driven after the current
  // one, so a command with count N is driven on N+1 enabled edges. The op is
  // kept in cur_op so that after a pause (which forces j/k to 00) the same op
  // can be re-driven while the countdown resumes where it stopped. On the
  // last cycle of a command the next queued one is loaded directly, so there
  // is no 00 gap between consecutive commands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rem    <= '0;
      cur_op <= 2'b00;
      j      <= 1'b0;
      k      <= 1'b0;
    end else if (!en) begin
      j <= 1'b0;
      k <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_nonempty) begin
            {j, k} <= head_op;
            cur_op <= head_op;
            rem    <= head_cnt;
            state  <= ST_RUN;
          end else begin
            {j, k} <= 2'b00;
          end
        end
        ST_RUN: begin
          if (rem != '0) begin
            rem    <= rem - CW'(1);
            {j, k} <= cur_op;
          end else if (fifo_nonempty) begin
            {j, k} <= head_op;
            cur_op <= head_op;
            rem    <= head_cnt;
          end else begin
            {j, k} <= 2'b00;
            state  <= ST_IDLE;
          end
        end
        default: begin
          {j, k} <= 2'b00;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Model of the downstream flop's q. It samples the same registered j/k
  // that the flop sees, so after each edge q_exp equals the flop's q. It runs
  // regardless of en because the flop itself is always clocked.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_exp <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q_exp <= 1'b0;
        2'b10:   q_exp <= 1'b1;
        2'b11:   q_exp <= ~q_exp;
        default: q_exp <= q_exp;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_sequencer
//
// Self-checking bench for jk_cmd_sequencer (DEPTH=4, CW=4). A behavioural
// model built on a command queue predicts j/k/q_exp/busy/level/in_ready
// every cycle; a vector table and hand-written sequences add fixed
// expectations for reset, single set, back-to-back toggle, backpressure,
// pause, maximum count and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [CW-1:0] in_cnt;
  logic          j;
  logic          k;
  logic          q_exp;
  logic          busy;
  logic [LW-1:0] level;

  int checks   = 0;
  int failures = 0;

  // Reference model state: queued commands, the active op and how many
  // driven cycles it still has left, and the predicted registered outputs.
  logic [1:0] mq_op  [$];
  int         mq_cnt [$];
  bit         m_active;
  logic [1:0] m_op;
  int         m_left;
  logic       m_j;
  logic       m_k;
  logic       m_q;

  typedef struct {
    logic          en;
    logic          valid;
    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic          ej;
    logic          ek;
    logic          eq;
    logic          ebusy;
    int            elevel;
  } vec_t;

  vec_t vecs [14];

  jk_cmd_sequencer #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_cnt   (in_cnt),
    .j        (j),
    .k        (k),
    .q_exp    (q_exp),
    .busy     (busy),
    .level    (level)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a mismatch.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_op.delete();
    mq_cnt.delete();
    m_active = 1'b0;
    m_op     = 2'b00;
    m_left   = 0;
    m_j      = 1'b0;
    m_k      = 1'b0;
    m_q      = 1'b0;
  endtask

  // One clock edge of the reference model, using the inputs currently
  // driven. The queue is inspected before the push so an accepted command
  // cannot be started in the same edge.
  task automatic model_edge();
    logic [1:0] nxt;
    bit         accept;
    accept = in_valid && (mq_op.size() < DEPTH);
    case ({m_j, m_k})
      2'b01:   m_q = 1'b0;
      2'b10:   m_q = 1'b1;
      2'b11:   m_q = ~m_q;
      default: ;
    endcase
    nxt = 2'b00;
    if (en) begin
      if (m_active && m_left > 0) begin
        nxt = m_op;
        m_left--;
      end else if (mq_op.size() > 0) begin
        m_op     = mq_op.pop_front();
        m_left   = mq_cnt.pop_front() + 1;
        nxt      = m_op;
        m_left--;
        m_active = 1'b1;
      end else begin
        m_active = 1'b0;
      end
    end
    if (accept) begin
      mq_op.push_back(in_op);
      mq_cnt.push_back(int'(in_cnt));
    end
    {m_j, m_k} = nxt;
  endtask

  // Compare every DUT output with the model.
  task automatic checkOutput(input string tag);
    chk({tag, ".j"},        32'(j),        32'(m_j));
    chk({tag, ".k"},        32'(k),        32'(m_k));
    chk({tag, ".q_exp"},    32'(q_exp),    32'(m_q));
    chk({tag, ".busy"},     32'(busy),     32'(m_active || (mq_op.size() > 0)));
    chk({tag, ".level"},    32'(level),    32'(mq_op.size()));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(mq_op.size() != DEPTH));
  endtask

  // Drive one cycle of inputs (called just after a rising edge), check the
  // pre-edge in_ready, advance one edge and check all outputs.
  task automatic applyStimulus(input logic e, input logic v, input logic [1:0] op,
                               input logic [CW-1:0] cnt, input string tag);
    en       = e;
    in_valid = v;
    in_op    = op;
    in_cnt   = cnt;
    #1;
    chk({tag, ".pre_ready"}, 32'(in_ready), 32'(mq_op.size() != DEPTH));
    @(posedge clk);
    model_edge();
    #1;
    checkOutput(tag);
  endtask

  function automatic vec_t mk(input logic e, input logic v, input logic [1:0] op, input int cnt,
                              input logic ej, input logic ek, input logic eq, input logic eb,
                              input int el);
    vec_t r;
    r.en     = e;
    r.valid  = v;
    r.op     = op;
    r.cnt    = CW'(cnt);
    r.ej     = ej;
    r.ek     = ek;
    r.eq     = eq;
    r.ebusy  = eb;
    r.elevel = el;
    return r;
  endfunction

  initial begin
    logic [1:0] fill_op  [5];
    int         fill_cnt [5];
    logic [1:0] drain_seq [8];
    int         driven;

    // Back-to-back toggle (cnt=3) then reset (cnt=0), then a single set
    // (cnt=2). Expected values are after the edge of each row.
    vecs[0]  = mk(1'b1, 1'b1, 2'b11, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    vecs[1]  = mk(1'b1, 1'b1, 2'b01, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    vecs[2]  = mk(1'b1, 1'b0, 2'b00, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    vecs[3]  = mk(1'b1, 1'b0, 2'b00, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1);
    vecs[4]  = mk(1'b1, 1'b0, 2'b00, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    vecs[5]  = mk(1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    vecs[6]  = mk(1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[7]  = mk(1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    vecs[8]  = mk(1'b1, 1'b1, 2'b10, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    vecs[9]  = mk(1'b1, 1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    vecs[10] = mk(1'b1, 1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    vecs[11] = mk(1'b1, 1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b1, 1'b1, 0);
    vecs[12] = mk(1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    vecs[13] = mk(1'b1, 1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    fill_op  = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    fill_cnt = '{0, 1, 0, 2, 0};
    drain_seq = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00};

    // Reset held for three edges, then released away from the edge.
    rst      = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    in_op    = 2'b00;
    in_cnt   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.j",        32'(j),        32'd0);
    chk("reset.k",        32'(k),        32'd0);
    chk("reset.q_exp",    32'(q_exp),    32'd0);
    chk("reset.busy",     32'(busy),     32'd0);
    chk("reset.level",    32'(level),    32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;

    // Idle with nothing offered.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, '0, "idle");
      chk("idle.jk",       32'({j, k}),   32'd0);
      chk("idle.q_exp",    32'(q_exp),    32'd0);
      chk("idle.busy",     32'(busy),     32'd0);
      chk("idle.level",    32'(level),    32'd0);
      chk("idle.in_ready", 32'(in_ready), 32'd1);
    end

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].op, vecs[i].cnt, "vec");
      chk($sformatf("vec%0d.j", i),     32'(j),     32'(vecs[i].ej));
      chk($sformatf("vec%0d.k", i),     32'(k),     32'(vecs[i].ek));
      chk($sformatf("vec%0d.q_exp", i), 32'(q_exp), 32'(vecs[i].eq));
      chk($sformatf("vec%0d.busy", i),  32'(busy),  32'(vecs[i].ebusy));
      chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].elevel));
    end

    // Backpressure: paused, offer five commands into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, fill_op[i], CW'(fill_cnt[i]), "fill");
      if (i == 3) begin
        chk("fill.level_full", 32'(level),    32'd4);
        chk("fill.ready_low",  32'(in_ready), 32'd0);
      end
    end
    chk("fill.held_off", 32'(level), 32'd4);
    applyStimulus(1'b1, 1'b0, 2'b00, '0, "drain");
    chk("drain0.jk",       32'({j, k}),   32'(drain_seq[0]));
    chk("drain0.level",    32'(level),    32'd3);
    chk("drain0.in_ready", 32'(in_ready), 32'd1);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, '0, "drain");
      chk($sformatf("drain%0d.jk", i), 32'({j, k}), 32'(drain_seq[i]));
    end
    chk("drain.busy", 32'(busy), 32'd0);

    // Pause mid-command: set with cnt=5, two driven cycles, three paused,
    // then the remainder.
    driven = 0;
    applyStimulus(1'b1, 1'b1, 2'b10, CW'(5), "pause.push");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, '0, "pause.run");
      if ({j, k} == 2'b10) driven++;
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b00, '0, "pause.hold");
      chk("pause.hold_jk", 32'({j, k}), 32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, '0, "pause.resume");
      if ({j, k} == 2'b10) driven++;
    end
    chk("pause.total_set_cycles", 32'(driven), 32'd6);
    chk("pause.busy_end",         32'(busy),   32'd0);

    // Maximum count: 2^CW driven cycles.
    driven = 0;
    applyStimulus(1'b1, 1'b1, 2'b11, CW'(15), "maxcnt.push");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, '0, "maxcnt.run");
      if ({j, k} == 2'b11) driven++;
    end
    chk("maxcnt.toggle_cycles", 32'(driven), 32'd16);

    // Randomised traffic against the model, then drain to idle.
    for (int i = 0; i < 400; i++) begin
      int c;
      c = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      applyStimulus(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), CW'(c), "rand");
    end
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, '0, "rand.drain");
    end
    chk("rand.idle_busy", 32'(busy), 32'd0);

    // Asynchronous reset during a toggle burst with three queued commands.
    applyStimulus(1'b1, 1'b1, 2'b11, CW'(7), "areset.push");
    applyStimulus(1'b1, 1'b1, 2'b10, CW'(1), "areset.push");
    applyStimulus(1'b1, 1'b1, 2'b01, CW'(2), "areset.push");
    applyStimulus(1'b1, 1'b1, 2'b10, CW'(3), "areset.push");
    chk("areset.level_before", 32'(level), 32'd3);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("areset.j",        32'(j),        32'd0);
    chk("areset.k",        32'(k),        32'd0);
    chk("areset.q_exp",    32'(q_exp),    32'd0);
    chk("areset.level",    32'(level),    32'd0);
    chk("areset.busy",     32'(busy),     32'd0);
    chk("areset.in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 2'b00, '0, "areset.after");
      chk("areset.after_jk",   32'({j, k}), 32'd0);
      chk("areset.after_busy", 32'(busy),   32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
